evaluador_tablero: RTL and testbench

Post-move board evaluator for the 2048 game. It consumes the 4×4 board produced by the move logic and scans it cell by cell. It reports `win`/`lose` back to the state machine and, when compiled in, spawns a new tile into a pseudo-randomly chosen empty cell. It sits between the move datapath (board writer) and `maquina_estados` (win/lose reader), closing the loop in the game top level.

---
 rtl/tablero_pkg.sv | 36 +++
 rtl/evaluador_tablero_lfsr16.sv | 24 ++
 rtl/evaluador_tablero.sv | 173 +++++++++++++++++
 tb/tb_evaluador_tablero.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tablero_pkg.sv
// Shared types and constants for the 2048 post-move board evaluator.
package tablero_pkg;

    typedef logic [11:0] celda_t;
    typedef celda_t [0:3][0:3] tablero_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_PLACE = 2'd2,
        ST_DONE  = 2'd3
    } eval_estado_t;

    localparam celda_t TILE_2 = 12'd2;
    localparam celda_t TILE_4 = 12'd4;

    // Fibonacci taps 16,14,13,11 on a right-shifting register (bit 0 is tap 16).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // True when any in-board orthogonal neighbour of pos holds value t.
    function automatic logic vecino_igual(input tablero_t b, input logic [3:0] pos,
                                          input celda_t t);
        logic [1:0] f;
        logic [1:0] c;
        logic       res;
        f   = pos[3:2];
        c   = pos[1:0];
        res = 1'b0;
        if ((f != 2'd0) && (b[f - 2'd1][c] == t)) res = 1'b1;
        if ((f != 2'd3) && (b[f + 2'd1][c] == t)) res = 1'b1;
        if ((c != 2'd0) && (b[f][c - 2'd1] == t)) res = 1'b1;
        if ((c != 2'd3) && (b[f][c + 2'd1] == t)) res = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/evaluador_tablero_lfsr16.sv
// 16-bit Fibonacci LFSR used to pick the spawn cell and tile value.
module lfsr16
    import tablero_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    // Shift register; advances only when step is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (step) begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/evaluador_tablero.sv
// Post-move 2048 board evaluator: scans for win/lose and optionally spawns a tile.
// Tile spawning (PLACE state, LFSR, spawn_* outputs) is built only with EVAL_SPAWN_EN.
module evaluador_tablero
    import tablero_pkg::*;
#(
    parameter logic [11:0] META    = 12'd2048,
    parameter logic [15:0] SEMILLA = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [0:3][0:3][11:0]   matriz_in,
    output logic                    busy,
    output logic                    fin,
    output logic                    win,
    output logic                    lose,
    output logic [0:3][0:3][11:0]   matriz,
    output logic                    spawn_valid,
    output logic [3:0]              spawn_pos
);

    eval_estado_t estado_r;
    tablero_t     tablero_r;
    logic [3:0]   idx_r;
    logic [4:0]   vacias_r;
    logic         win_f_r;
    logic         merge_f_r;

    logic [1:0]   fila_s;
    logic [1:0]   col_s;
    celda_t       celda_s;
    logic         es_vacia_s;
    logic [4:0]   vacias_s;
    logic         win_s;
    logic         merge_s;
    logic         a_place_s;
    logic [3:0]   idx_place_s;

    // Per-cell evaluation of the cell under idx, folded into the running flags.
    always_comb begin
        fila_s     = idx_r[3:2];
        col_s      = idx_r[1:0];
        celda_s    = tablero_r[fila_s][col_s];
        es_vacia_s = (celda_s == 12'd0);
        vacias_s   = vacias_r + {4'd0, es_vacia_s};
        win_s      = win_f_r | (celda_s == META);
        merge_s    = merge_f_r | ((celda_s != 12'd0) &&
                     (((col_s != 2'd3) && (tablero_r[fila_s][col_s + 2'd1] == celda_s)) ||
                      ((fila_s != 2'd3) && (tablero_r[fila_s + 2'd1][col_s] == celda_s))));
    end

`ifdef EVAL_SPAWN_EN
    logic [15:0] lfsr_s;
    logic        step_s;
    logic [7:0]  sel_r;
    celda_t      ficha_s;
    tablero_t    colocado_s;

    assign step_s      = (estado_r == ST_IDLE) && start;
    assign a_place_s   = !win_s && (vacias_s != 5'd0);
    assign idx_place_s = sel_r[3:0];

    lfsr16 #(.SEED(SEMILLA)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (step_s),
        .q    (lfsr_s)
    );

    // Board as it would look with the new tile written at the probed cell.
    always_comb begin
        ficha_s                    = (sel_r[7:4] == 4'd0) ? TILE_4 : TILE_2;
        colocado_s                 = tablero_r;
        colocado_s[fila_s][col_s]  = ficha_s;
    end
`else
    assign a_place_s   = 1'b0;
    assign idx_place_s = 4'd0;
    assign spawn_valid = 1'b0;
    assign spawn_pos   = 4'd0;
`endif

    // Evaluation FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r  <= ST_IDLE;
            tablero_r <= '0;
            idx_r     <= 4'd0;
            vacias_r  <= 5'd0;
            win_f_r   <= 1'b0;
            merge_f_r <= 1'b0;
            busy      <= 1'b0;
            fin       <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
            matriz    <= '0;
`ifdef EVAL_SPAWN_EN
            sel_r       <= 8'd0;
            spawn_valid <= 1'b0;
            spawn_pos   <= 4'd0;
`endif
        end else begin
            case (estado_r)
                ST_IDLE: begin
                    fin <= 1'b0;
                    if (start) begin
                        tablero_r <= matriz_in;
                        vacias_r  <= 5'd0;
                        win_f_r   <= 1'b0;
                        merge_f_r <= 1'b0;
                        idx_r     <= 4'd0;
                        busy      <= 1'b1;
                        estado_r  <= ST_SCAN;
`ifdef EVAL_SPAWN_EN
                        sel_r     <= lfsr_s[7:0];
`endif
                    end
                end
                ST_SCAN: begin
                    vacias_r  <= vacias_s;
                    win_f_r   <= win_s;
                    merge_f_r <= merge_s;
                    idx_r     <= idx_r + 4'd1;
                    if (idx_r == 4'd15) begin
                        if (a_place_s) begin
                            idx_r    <= idx_place_s;
                            estado_r <= ST_PLACE;
                        end else begin
                            estado_r <= ST_DONE;
                            fin      <= 1'b1;
                            matriz   <= tablero_r;
                            win      <= win_s;
                            lose     <= !win_s && (vacias_s == 5'd0) && !merge_s;
`ifdef EVAL_SPAWN_EN
                            spawn_valid <= 1'b0;
                            spawn_pos   <= 4'd0;
`endif
                        end
                    end
                end
`ifdef EVAL_SPAWN_EN
                ST_PLACE: begin
                    if (es_vacia_s) begin
                        tablero_r   <= colocado_s;
                        matriz      <= colocado_s;
                        estado_r    <= ST_DONE;
                        fin         <= 1'b1;
                        win         <= 1'b0;
                        // Filling the last hole loses only if the new tile has no partner.
                        lose        <= (vacias_r == 5'd1) && !merge_f_r &&
                                       !vecino_igual(tablero_r, idx_r, ficha_s);
                        spawn_valid <= 1'b1;
                        spawn_pos   <= idx_r;
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
`endif
                ST_DONE: begin
                    fin      <= 1'b0;
                    busy     <= 1'b0;
                    estado_r <= ST_IDLE;
                end
                default: begin
                    fin      <= 1'b0;
                    busy     <= 1'b0;
                    estado_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evaluador_tablero.sv
// Self-checking bench for evaluador_tablero against a board-level reference model.
module tb_evaluador_tablero;
    import tablero_pkg::*;

    typedef struct packed {
        logic [5:0] lat;
        logic       win;
        logic       lose;
        logic       sv;
        logic [3:0] sp;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    tablero_t   matriz_in;
    tablero_t   matriz;
    logic       busy;
    logic       fin;
    logic       win;
    logic       lose;
    logic       spawn_valid;
    logic [3:0] spawn_pos;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    evaluador_tablero #(.META(12'd2048), .SEMILLA(16'hACE1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .matriz_in   (matriz_in),
        .busy        (busy),
        .fin         (fin),
        .win         (win),
        .lose        (lose),
        .matriz      (matriz),
        .spawn_valid (spawn_valid),
        .spawn_pos   (spawn_pos)
    );

    // Reference LFSR step: feedback is the XOR of the bits at taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        int taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        for (int i = 0; i < 4; i++) fb ^= x[16 - taps[i]];
        return {fb, x[15:1]};
    endfunction

    function automatic bit hay_pareja(input tablero_t b);
        bit p = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] != 12'd0) begin
                    if (c < 3 && b[r][c+1] == b[r][c]) p = 1'b1;
                    if (r < 3 && b[r+1][c] == b[r][c]) p = 1'b1;
                end
        return p;
    endfunction

    // Board-level model: expected latency, flags and resulting board.
    task automatic modelo(input tablero_t b, input logic [15:0] sel,
                          output res_t r, output tablero_t nb);
        int vac = 0;
        bit gana = 1'b0;
        nb = b;
        r  = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i/4][i%4] == 12'd0) vac++;
            if (b[i/4][i%4] == 12'd2048) gana = 1'b1;
        end
        r.win = gana;
        r.lat = 6'd16;
`ifdef EVAL_SPAWN_EN
        if (!gana && vac > 0) begin
            int p = int'(sel[3:0]);
            int k = 0;
            while (nb[p/4][p%4] != 12'd0) begin
                p = (p + 1) % 16;
                k++;
            end
            nb[p/4][p%4] = (sel[7:4] == 4'd0) ? 12'd4 : 12'd2;
            r.sv  = 1'b1;
            r.sp  = 4'(p);
            r.lat = 6'(17 + k);
            vac--;
        end
`endif
        r.lose = !gana && (vac == 0) && !hay_pareja(nb);
    endtask

    function automatic tablero_t ajedrez(input celda_t a, input celda_t b);
        tablero_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = ((r + c) % 2 == 0) ? a : b;
        return t;
    endfunction

    function automatic tablero_t tablero_aleatorio(input int modo);
        tablero_t t = '0;
        celda_t   a;
        celda_t   b;
        case (modo)
            0: begin
                for (int i = 0; i < 16; i++)
                    t[i/4][i%4] = ($urandom_range(0, 3) == 0) ? 12'd0
                                  : celda_t'(1 << $urandom_range(1, 10));
                if ($urandom_range(0, 7) == 0) t[$urandom_range(0, 3)][$urandom_range(0, 3)] = 12'd2048;
            end
            1: for (int i = 0; i < 16; i++) t[i/4][i%4] = celda_t'(1 << $urandom_range(1, 4));
            2: begin
                a = celda_t'(1 << $urandom_range(1, 4));
                b = celda_t'(1 << $urandom_range(5, 8));
                t = ajedrez(a, b);
                t[$urandom_range(0, 3)][$urandom_range(0, 3)] = 12'd0;
            end
            default: if ($urandom_range(0, 1) == 1) t[$urandom_range(0, 3)][$urandom_range(0, 3)] = 12'd8;
        endcase
        return t;
    endfunction

    // Drives one evaluation and captures what the DUT reports at fin (lat 0 = timeout).
    task automatic ejecutar(input tablero_t b, input bit pulso, output res_t obs, output tablero_t ob);
        @(negedge clk);
        matriz_in = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lfsr_m    = lfsr_next(lfsr_m);
        matriz_in = tablero_aleatorio(1);
        obs       = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = (pulso && c == 2);
            if (fin) begin
                obs.lat = 6'(c);
                break;
            end
        end
        start   = 1'b0;
        obs.win  = win;
        obs.lose = lose;
        obs.sv   = spawn_valid;
        obs.sp   = spawn_valid ? spawn_pos : 4'd0;
        ob       = matriz;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        lfsr_m = 16'hACE1;
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, fin, win, lose, spawn_valid, spawn_pos} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, want 0", {busy, fin, win, lose, spawn_valid, spawn_pos});
        end
        tests_run++;
        if (matriz !== '0) begin
            tests_failed++;
            $display("FAIL reset_matriz: got %h, want 0", matriz);
        end
    endtask

    task automatic evaluar(input string nombre, input tablero_t b, input bit pulso);
        res_t exp_r, obs_r;
        tablero_t exp_b, obs_b;
        modelo(b, lfsr_m, exp_r, exp_b);
        ejecutar(b, pulso, obs_r, obs_b);
        tests_run++;
        if (obs_r !== exp_r) begin
            tests_failed++;
            $display("FAIL %s_result: got lat=%0d win=%b lose=%b sv=%b sp=%0d, want lat=%0d win=%b lose=%b sv=%b sp=%0d",
                     nombre, obs_r.lat, obs_r.win, obs_r.lose, obs_r.sv, obs_r.sp,
                     exp_r.lat, exp_r.win, exp_r.lose, exp_r.sv, exp_r.sp);
        end
        tests_run++;
        if (obs_b !== exp_b) begin
            tests_failed++;
            $display("FAIL %s_matriz: got %h, want %h", nombre, obs_b, exp_b);
        end
    endtask

    task automatic test_first_spawn;
        evaluar("empty_board", '0, 1'b0);
    endtask

    task automatic test_win;
        tablero_t t = '0;
        t[2][1] = 12'd2048;
        evaluar("win_board", t, 1'b0);
    endtask

    task automatic test_checkerboard;
        evaluar("checker_full", ajedrez(12'd2, 12'd4), 1'b0);
    endtask

    task automatic test_checker_hole;
        tablero_t t = ajedrez(12'd2, 12'd4);
        t[3][3] = 12'd0;
        test_reset();
        evaluar("checker_hole", t, 1'b0);
    endtask

    task automatic test_start_ignored;
        bit extra = 1'b0;
        evaluar("start_ignored", tablero_aleatorio(0), 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (busy) extra = 1'b1;
        end
        tests_run++;
        if (extra !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_queue_busy: got %b, want 0", extra);
        end
    endtask

    task automatic test_reset_abort;
        tablero_t t = '0;
        t[0][0] = 12'd2048;
        evaluar("win_before_abort", t, 1'b0);
        @(negedge clk);
        matriz_in = tablero_aleatorio(0);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        lfsr_m = 16'hACE1;
        tests_run++;
        if ({busy, fin, win, lose, spawn_valid, spawn_pos} !== 9'd0 || matriz !== '0) begin
            tests_failed++;
            $display("FAIL abort_reset: got flags=%b matriz=%h, want 0", {busy, fin, win, lose, spawn_valid, spawn_pos}, matriz);
        end
        evaluar("after_abort", '0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++)
            evaluar("random", tablero_aleatorio(n % 4), 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        matriz_in = '0;
        lfsr_m    = 16'hACE1;
        test_reset();
        test_first_spawn();
        test_win();
        test_checkerboard();
        test_checker_hole();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
